contador_4b: RTL and testbench



---
 rtl/contador_4b.sv | 73 +++++++
 tb/tb_contador_4b.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/contador_4b.sv
// 4-bit multi-mode counter: up by 1, down by 1, down by 3, or parallel load, with a wrap flag (RCO).
// Define CONTADOR_RCO_LOOKAHEAD_EN to get a combinational lookahead RCO instead of the registered one.
module contador_4b (
  input  logic       CLK,
  input  logic       RESET_L,
  input  logic       ENB,
  input  logic [1:0] MODO,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       RCO
);

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN  = 2'b01,
    MODE_DOWN3 = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  mode_t      mode;
  logic [3:0] q_next;
  logic       wrap;

  assign mode = mode_t'(MODO);

  // wrap means this edge's update crosses the 0/15 boundary; loads never wrap
  always_comb begin
    q_next = Q;
    wrap   = 1'b0;
    if (ENB) begin
      unique case (mode)
        MODE_UP: begin
          q_next = Q + 4'd1;
          wrap   = (Q == 4'hF);
        end
        MODE_DOWN: begin
          q_next = Q - 4'd1;
          wrap   = (Q == 4'h0);
        end
        MODE_DOWN3: begin
          q_next = Q - 4'd3;
          wrap   = (Q < 4'd3);
        end
        MODE_LOAD: begin
          q_next = D;
          wrap   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      Q <= 4'h0;
    end else begin
      Q <= q_next;
    end
  end

`ifdef CONTADOR_RCO_LOOKAHEAD_EN
  // high in the cycle before the wrapping edge so a following stage can use it as its enable
  assign RCO = wrap & RESET_L;
`else
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      RCO <= 1'b0;
    end else begin
      RCO <= wrap;
    end
  end
`endif

endmodule

// File: tb/tb_contador_4b.sv
// Self-checking bench for contador_4b: directed test-plan sequences plus randomized traffic
// compared every cycle against an integer-arithmetic model of the counter.
module tb_contador_4b;

  logic       CLK = 1'b0;
  logic       RESET_L = 1'b1;
  logic       ENB = 1'b0;
  logic [1:0] MODO = 2'b00;
  logic [3:0] D = 4'h0;
  logic [3:0] Q;
  logic       RCO;

  int model_q = 0;
  bit model_rco = 1'b0;
  bit check_en = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  contador_4b dut (
    .CLK(CLK),
    .RESET_L(RESET_L),
    .ENB(ENB),
    .MODO(MODO),
    .D(D),
    .Q(Q),
    .RCO(RCO)
  );

  always #5 CLK = ~CLK;

  function automatic int step_of(int modo);
    if (modo == 0) return 1;
    if (modo == 1) return -1;
    return -3;
  endfunction

  function automatic bit wraps(int q, int modo, bit enb);
    int s;
    if (!enb || modo == 3) return 1'b0;
    s = q + step_of(modo);
    return (s < 0) || (s > 15);
  endfunction

  function automatic int next_q(int q, int modo, bit enb, int d);
    if (!enb) return q;
    if (modo == 3) return d;
    return (q + step_of(modo) + 16) % 16;
  endfunction

  function automatic bit expected_rco();
`ifdef CONTADOR_RCO_LOOKAHEAD_EN
    return RESET_L && wraps(model_q, int'(MODO), ENB);
`else
    return model_rco;
`endif
  endfunction

  always @(negedge RESET_L) begin
    model_q = 0;
    model_rco = 1'b0;
  end

  always @(posedge CLK) begin
    if (RESET_L) begin
      model_rco = wraps(model_q, int'(MODO), ENB);
      model_q = next_q(model_q, int'(MODO), ENB, int'(D));
    end
  end

  task automatic compare(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle away from the active edge
  always @(negedge CLK) begin
    if (check_en) begin
      compare("model_q", int'(Q), model_q);
      compare("model_rco", int'(RCO), int'(expected_rco()));
    end
  end

  task automatic checkOutput(input string name, input int exp_q, input int exp_rco);
    compare({name, "_q"}, int'(Q), exp_q);
`ifndef CONTADOR_RCO_LOOKAHEAD_EN
    compare({name, "_rco"}, int'(RCO), exp_rco);
`endif
  endtask

  task automatic applyStimulus(input bit enb, input logic [1:0] modo, input logic [3:0] d);
    ENB = enb;
    MODO = modo;
    D = d;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #1 RESET_L = 1'b0;
    check_en = 1'b1;
    ENB = 1'b1;
    MODO = 2'b00;
    repeat (2) @(posedge CLK);
    #2;
    checkOutput("reset_hold", 0, 0);
    RESET_L = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("first_after_reset", 1, 0);

    applyStimulus(1'b1, 2'b11, 4'h9);
    checkOutput("load9", 9, 0);
    #1 RESET_L = 1'b0;
    #1 checkOutput("async_reset", 0, 0);
    @(posedge CLK);
    #2 RESET_L = 1'b1;
    applyStimulus(1'b1, 2'b00, 4'h9);
    checkOutput("release_up", 1, 0);

    applyStimulus(1'b1, 2'b11, 4'hE);
    checkOutput("load14", 14, 0);
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("up15", 15, 0);
`ifdef CONTADOR_RCO_LOOKAHEAD_EN
    compare("lookahead_at15", int'(RCO), 1);
`endif
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("up_wrap0", 0, 1);
    applyStimulus(1'b1, 2'b00, 4'h0);
    checkOutput("up1", 1, 0);

    applyStimulus(1'b1, 2'b11, 4'h1);
    applyStimulus(1'b1, 2'b01, 4'h0);
    checkOutput("down0", 0, 0);
    applyStimulus(1'b1, 2'b01, 4'h0);
    checkOutput("down_wrap15", 15, 1);

    applyStimulus(1'b1, 2'b11, 4'h7);
    applyStimulus(1'b1, 2'b10, 4'h0);
    checkOutput("by3_4", 4, 0);
    applyStimulus(1'b1, 2'b10, 4'h0);
    checkOutput("by3_1", 1, 0);
    applyStimulus(1'b1, 2'b10, 4'h0);
    checkOutput("by3_wrap14", 14, 1);
    applyStimulus(1'b1, 2'b10, 4'h0);
    checkOutput("by3_11", 11, 0);

    applyStimulus(1'b1, 2'b11, 4'hA);
    checkOutput("loadA", 10, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00, 4'h3);
      checkOutput("hold", 10, 0);
    end

    applyStimulus(1'b1, 2'b11, 4'h5);
    applyStimulus(1'b1, 2'b00, 4'($urandom_range(1, 15)));
    checkOutput("switch_up", 6, 0);
    applyStimulus(1'b1, 2'b01, 4'($urandom_range(1, 15)));
    checkOutput("switch_down", 5, 0);
    applyStimulus(1'b1, 2'b10, 4'($urandom_range(1, 15)));
    checkOutput("switch_by3", 2, 0);

    // Randomized traffic with occasional asynchronous reset pulses inside a cycle
    for (int i = 0; i < 600; i++) begin
      ENB = ($urandom_range(0, 7) != 0);
      MODO = 2'($urandom_range(0, 3));
      D = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #1 RESET_L = 1'b0;
        #5 RESET_L = 1'b1;
      end
      @(posedge CLK);
      #2;
    end

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
